// File: rtl/flu_sched.sv
// flu_sched: round-robin scheduler that shares one combinational FLU between
// two requesters. Operands are registered toward the FLU, the result is sampled
// after FLU_LAT settle cycles and returned with the issuing requester's ID.
// Optional feature: define FLU_SCHED_OPCHECK_EN to reject ops with ctl==0 or
// ctl>9 (accepted, answered next cycle with resp_data=0 and resp_err=1).
module flu_sched #(
  parameter int W       = 32,
  parameter int CTL_W   = 4,
  parameter int FLU_LAT = 1    // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [CTL_W-1:0] req0_ctl,
  // requester 1
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [CTL_W-1:0] req1_ctl,
  // FLU interface
  output logic [W-1:0]     flu_a,
  output logic [W-1:0]     flu_b,
  output logic [CTL_W-1:0] flu_ctl,
  input  logic [W-1:0]     flu_out,
  // response channel
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [W-1:0]     resp_data,
  output logic             resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             last_grant;
  logic [3:0]       cnt;

  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             grant_id;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic [CTL_W-1:0] sel_ctl;
  logic             sel_illegal;

  // Round-robin arbitration: a lone requester wins; on a tie the one that
  // was not served last wins.
  assign grant0   = req0_valid && (!req1_valid || last_grant);
  assign grant1   = req1_valid && (!req0_valid || !last_grant);
  assign accept   = (state == IDLE) && (grant0 || grant1);
  assign grant_id = grant1;

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_ctl = grant1 ? req1_ctl : req0_ctl;

`ifdef FLU_SCHED_OPCHECK_EN
  // Op selects outside 1..9 are answered locally with an error flag.
  assign sel_illegal = (sel_ctl == '0) || (sel_ctl > CTL_W'(9));
`else
  assign sel_illegal = 1'b0;
`endif

  // The response is valid exactly while the FSM sits in RESP.
  assign resp_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (accept) state_next = sel_illegal ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, settle countdown, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      flu_a      <= '0;
      flu_b      <= '0;
      flu_ctl    <= '0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      last_grant <= 1'b1;   // requester 0 wins the first tie
      cnt        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            resp_id    <= grant_id;
            last_grant <= grant_id;
            cnt        <= 4'(FLU_LAT - 1);
            if (sel_illegal) begin
              // FLU operands keep their last issued values.
              resp_data <= '0;
              resp_err  <= 1'b1;
            end else begin
              flu_a    <= sel_a;
              flu_b    <= sel_b;
              flu_ctl  <= sel_ctl;
              resp_err <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) cnt       <= cnt - 4'd1;
          else           resp_data <= flu_out;
        end
        default: ;  // RESP holds all response fields until the handshake
      endcase
    end
  end

endmodule

// File: tb/tb_flu_sched.sv
// tb_flu_sched: self-checking bench for flu_sched. A behavioural FLU model
// drives flu_out; a scoreboard queues the expected response on every accept
// and compares it when the response handshake completes. A second instance
// with FLU_LAT=3 exercises the settle counter and reset during WAIT.
module tb_flu_sched;

  localparam int W     = 32;
  localparam int CTL_W = 4;
  localparam logic [W-1:0] F10_2 = 32'h41233333;
  localparam logic [W-1:0] F5_1  = 32'h40A33333;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rst_s;
  logic             req0_valid, req1_valid, req0_valid_s, req1_valid_s;
  logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
  logic [CTL_W-1:0] req0_ctl, req1_ctl;
  logic             resp_ready;

  logic             req0_ready, req1_ready, resp_valid, resp_id, resp_err;
  logic [W-1:0]     flu_a, flu_b, flu_out, resp_data;
  logic [CTL_W-1:0] flu_ctl;

  logic             req0_ready_s, req1_ready_s, resp_valid_s, resp_id_s, resp_err_s;
  logic [W-1:0]     flu_a_s, flu_b_s, flu_out_s, resp_data_s;
  logic [CTL_W-1:0] flu_ctl_s;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;
  exp_t sb[$];
  exp_t mon_e;

  // Behavioural FLU stand-in: any deterministic function of {a, b, ctl}.
  function automatic logic [W-1:0] flu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [CTL_W-1:0] c);
    case (c)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return ~a;
      4'd9:    return b;
      default: return {a[15:0], b[15:0]} ^ {28'h5A5A5A5, c};
    endcase
  endfunction

  function automatic bit illegal_op(input logic [CTL_W-1:0] c);
`ifdef FLU_SCHED_OPCHECK_EN
    return (c == 4'd0) || (c > 4'd9);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t make_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [CTL_W-1:0] c);
    exp_t e;
    e.id   = id;
    e.err  = illegal_op(c);
    e.data = e.err ? '0 : flu_model(a, b, c);
    return e;
  endfunction

  assign flu_out   = flu_model(flu_a, flu_b, flu_ctl);
  assign flu_out_s = flu_model(flu_a_s, flu_b_s, flu_ctl_s);

  flu_sched #(.W(W), .CTL_W(CTL_W), .FLU_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .flu_a(flu_a), .flu_b(flu_b), .flu_ctl(flu_ctl), .flu_out(flu_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err)
  );

  flu_sched #(.W(W), .CTL_W(CTL_W), .FLU_LAT(3)) u_dut_slow (
    .clk(clk), .rst(rst_s),
    .req0_valid(req0_valid_s), .req0_ready(req0_ready_s),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid_s), .req1_ready(req1_ready_s),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
    .flu_a(flu_a_s), .flu_b(flu_b_s), .flu_ctl(flu_ctl_s), .flu_out(flu_out_s),
    .resp_valid(resp_valid_s), .resp_ready(resp_ready),
    .resp_id(resp_id_s), .resp_data(resp_data_s), .resp_err(resp_err_s)
  );

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard for the FLU_LAT=1 instance: push on accept, pop on response.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (req0_ready || req1_ready) begin
        vectors++;
        if (req0_ready && req1_ready) begin
          miscompares++;
          $display("FAIL both_ready: req0_ready=%b req1_ready=%b, required at most one high",
                   req0_ready, req1_ready);
        end
      end
      if (req0_valid && req0_ready)      sb.push_back(make_exp(1'b0, req0_a, req0_b, req0_ctl));
      else if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_a, req1_b, req1_ctl));
      if (resp_valid && resp_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp: id=%0d data=%h, required no response", resp_id, resp_data);
        end else begin
          mon_e = sb.pop_front();
          if ({resp_id, resp_data, resp_err} !== {mon_e.id, mon_e.data, mon_e.err}) begin
            miscompares++;
            $display("FAIL resp: got id=%0d data=%h err=%b, required id=%0d data=%h err=%b",
                     resp_id, resp_data, resp_err, mon_e.id, mon_e.data, mon_e.err);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst          = 1'b1;
    rst_s        = 1'b1;
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    req0_valid_s = 1'b0;
    req1_valid_s = 1'b0;
    resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    rst_s = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if ({flu_a, flu_b, flu_ctl, resp_valid, resp_id, resp_data, resp_err, req0_ready, req1_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_fast: flu_a=%h flu_b=%h flu_ctl=%h valid=%b id=%b data=%h err=%b, required all 0",
               flu_a, flu_b, flu_ctl, resp_valid, resp_id, resp_data, resp_err);
    end
    vectors++;
    if ({flu_a_s, flu_b_s, flu_ctl_s, resp_valid_s, resp_id_s, resp_data_s, resp_err_s} !== '0) begin
      miscompares++;
      $display("FAIL reset_slow: flu_a=%h flu_ctl=%h valid=%b data=%h, required all 0",
               flu_a_s, flu_ctl_s, resp_valid_s, resp_data_s);
    end
  endtask

  // Single op, FLU_LAT=1: ready in cycle 0, resp_valid in cycle 2.
  task automatic test_single();
    do_reset();
    @(posedge clk); #1;
    req0_a = F10_2; req0_b = F5_1; req0_ctl = 4'd1; req0_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready: req0_ready=%b req1_ready=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early: resp_valid=%b in cycle 1, required 0", resp_valid);
    end
    vectors++;
    if ({flu_a, flu_b, flu_ctl} !== {F10_2, F5_1, 4'd1}) begin
      miscompares++;
      $display("FAIL single_operands: flu_a=%h flu_b=%h flu_ctl=%h, required %h %h 1",
               flu_a, flu_b, flu_ctl, F10_2, F5_1);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_latency: resp_valid=%b in cycle 2, required 1", resp_valid);
    end
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release: resp_valid=%b after handshake, required 0", resp_valid);
    end
  endtask

  // Both requesters always valid, ctl sweep 1..9: grants alternate from req0.
  task automatic test_round_robin();
    int got;
    int prev;
    do_reset();
    prev = 0;
    @(posedge clk); #1;
    req0_a = $urandom; req0_b = $urandom; req0_ctl = 4'd1;
    req1_a = $urandom; req1_b = $urandom; req1_ctl = 4'd1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      got = -1;
      for (int c = 0; c < 12 && got < 0; c++) begin
        @(negedge clk);
        if (req0_ready)      got = 0;
        else if (req1_ready) got = 1;
      end
      vectors++;
      if (got !== (k - 1) % 2) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: granted %0d, required %0d", k, got, (k - 1) % 2);
      end
      if (k > 1) begin
        vectors++;
        if (cycle - prev !== 3) begin
          miscompares++;
          $display("FAIL rr_period[%0d]: %0d cycles between accepts, required 3", k, cycle - prev);
        end
      end
      prev = cycle;
      @(posedge clk); #1;
      req0_a = $urandom; req0_b = $urandom; req0_ctl = CTL_W'(k + 1);
      req1_a = $urandom; req1_b = $urandom; req1_ctl = CTL_W'(k + 1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // Response held under backpressure; no accept until the handshake.
  task automatic test_back_pressure();
    logic [W-1:0] want;
    do_reset();
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req0_a = F10_2; req0_b = F5_1; req0_ctl = 4'd2; req0_valid = 1'b1;
    req1_a = $urandom; req1_b = $urandom; req1_ctl = 4'd5; req1_valid = 1'b1;
    want = flu_model(F10_2, F5_1, 4'd2);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({resp_valid, resp_id, resp_data, req0_ready, req1_ready} !== {1'b1, 1'b0, want, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b id=%b data=%h rdy0=%b rdy1=%b, required 1 0 %h 0 0",
                 i, resp_valid, resp_id, resp_data, req0_ready, req1_ready, want);
      end
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_handshake_cycle: req1_ready=%b, required 0", req1_ready);
    end
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume: req1_ready=%b in cycle after handshake, required 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // FLU_LAT=3 instance: reset during WAIT aborts the op, then latency check.
  task automatic test_reset_wait();
    logic [W-1:0] want;
    do_reset();
    @(posedge clk); #1;
    req0_a = F10_2; req0_b = F5_1; req0_ctl = 4'd3; req0_valid_s = 1'b1;
    @(negedge clk);
    vectors++;
    if (req0_ready_s !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_accept: req0_ready=%b, required 1", req0_ready_s);
    end
    @(posedge clk); #1;
    req0_valid_s = 1'b0;
    @(posedge clk); #1;
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    @(negedge clk);
    vectors++;
    if ({flu_a_s, flu_b_s, flu_ctl_s, resp_valid_s, resp_id_s, resp_data_s, resp_err_s, req0_ready_s, req1_ready_s} !== '0) begin
      miscompares++;
      $display("FAIL rw_reset: flu_a=%h flu_ctl=%h valid=%b data=%h, required all 0",
               flu_a_s, flu_ctl_s, resp_valid_s, resp_data_s);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid_s !== 1'b0) begin
        miscompares++;
        $display("FAIL rw_no_resp[%0d]: resp_valid=%b, required 0", i, resp_valid_s);
      end
    end
    @(posedge clk); #1;
    req0_a = $urandom; req0_b = $urandom; req0_ctl = 4'd6;
    req1_a = $urandom; req1_b = $urandom; req1_ctl = 4'd7;
    req0_valid_s = 1'b1; req1_valid_s = 1'b1;
    want = flu_model(req0_a, req0_b, 4'd6);
    @(negedge clk);
    vectors++;
    if ({req0_ready_s, req1_ready_s} !== 2'b10) begin
      miscompares++;
      $display("FAIL rw_tie: req0_ready=%b req1_ready=%b, required 1 0", req0_ready_s, req1_ready_s);
    end
    @(posedge clk); #1;
    req0_valid_s = 1'b0; req1_valid_s = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (resp_valid_s !== (k == 4)) begin
        miscompares++;
        $display("FAIL rw_latency[%0d]: resp_valid=%b, required %b", k, resp_valid_s, (k == 4));
      end
    end
    vectors++;
    if ({resp_id_s, resp_data_s} !== {1'b0, want}) begin
      miscompares++;
      $display("FAIL rw_data: id=%b data=%h, required 0 %h", resp_id_s, resp_data_s, want);
    end
    repeat (2) @(posedge clk);
  endtask

  // ctl=12 from requester 1 after a legal op with ctl=3.
  task automatic test_illegal_op();
    do_reset();
    @(posedge clk); #1;
    req0_a = $urandom; req0_b = $urandom; req0_ctl = 4'd3; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    req1_a = $urandom; req1_b = $urandom; req1_ctl = 4'd12; req1_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (req1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_accept: req1_ready=%b, required 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    vectors++;
`ifdef FLU_SCHED_OPCHECK_EN
    if ({resp_valid, resp_err, resp_data, flu_ctl} !== {1'b1, 1'b1, {W{1'b0}}, 4'd3}) begin
      miscompares++;
      $display("FAIL illegal_fast_resp: valid=%b err=%b data=%h flu_ctl=%0d, required 1 1 0 3",
               resp_valid, resp_err, resp_data, flu_ctl);
    end
`else
    if ({resp_valid, resp_err, flu_ctl} !== {1'b0, 1'b0, 4'd12}) begin
      miscompares++;
      $display("FAIL illegal_issued: valid=%b err=%b flu_ctl=%0d, required 0 0 12",
               resp_valid, resp_err, flu_ctl);
    end
`endif
    repeat (4) @(posedge clk);
  endtask

  initial begin
    req0_a = '0; req0_b = '0; req0_ctl = '0;
    req1_a = '0; req1_b = '0; req1_ctl = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_wait();
    test_illegal_op();
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
